// File: rtl/riscv_lsu_if.sv
// Core-side request/response channel of the load/store unit.
// The master drives requests; the slave (the LSU) answers with a one-cycle
// response pulse.
interface riscv_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one request at a time and drives a single-port,
// word-wide RAM that has a one-cycle synchronous read and no byte enables.
// Loads are extracted and extended from the read word. SB/SH are done as a
// read-modify-write, and SW is written directly.
module riscv_lsu #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_lsu_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_data,
  output logic                  ram_wren,
  input  logic [31:0]           ram_q
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            func3_q, func3_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [31:0]           ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  logic                  resp_err_q, resp_err_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;

  logic                  func3_legal;
  logic                  misaligned;
  logic                  req_err;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [31:0]           load_ext;
  logic [31:0]           merged;

  // Decode the incoming request: an illegal funct3 or a misaligned address is an error.
  always_comb begin
    func3_legal = 1'b0;
    misaligned  = 1'b0;
    if (bus.req_store) begin
      func3_legal = (bus.req_func3 == 3'b000) || (bus.req_func3 == 3'b001) ||
                    (bus.req_func3 == 3'b010);
    end else begin
      func3_legal = (bus.req_func3 == 3'b000) || (bus.req_func3 == 3'b001) ||
                    (bus.req_func3 == 3'b010) || (bus.req_func3 == 3'b100) ||
                    (bus.req_func3 == 3'b101);
    end
    case (bus.req_func3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_err = !func3_legal || misaligned;
  end

  // Pick the addressed byte/halfword from the read word and extend it per funct3.
  always_comb begin
    byte_sel = ram_q[7:0];
    case (lane_q)
      2'd0:    byte_sel = ram_q[7:0];
      2'd1:    byte_sel = ram_q[15:8];
      2'd2:    byte_sel = ram_q[23:16];
      default: byte_sel = ram_q[31:24];
    endcase
    half_sel = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
    case (func3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = ram_q;
    endcase
  end

  // Merge the store data into the read word, leaving every other byte untouched.
  always_comb begin
    merged = ram_q;
    if (func3_q[0]) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Next-state and next-register values of the request FSM.
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    func3_d       = func3_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    resp_err_d    = resp_err_q;
    resp_rdata_d  = resp_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'd0;
            state_d      = ST_RESP;
          end else begin
            store_d       = bus.req_store;
            func3_d       = bus.req_func3;
            lane_d        = bus.req_addr[1:0];
            wdata_d       = bus.req_wdata[15:0];
            ram_address_d = bus.req_addr[ADDR_WIDTH+1:2];
            if (bus.req_store && (bus.req_func3 == 3'b010)) begin
              ram_data_d = bus.req_wdata;
              ram_wren_d = 1'b1;
              state_d    = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (store_q) begin
          ram_data_d = merged;
          ram_wren_d = 1'b1;
          state_d    = ST_WRITE;
        end else begin
          resp_err_d   = 1'b0;
          resp_rdata_d = load_ext;
          state_d      = ST_RESP;
        end
      end
      ST_WRITE: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      store_q       <= 1'b0;
      func3_q       <= 3'd0;
      lane_q        <= 2'd0;
      wdata_q       <= 16'd0;
      ram_address_q <= '0;
      ram_data_q    <= 32'd0;
      ram_wren_q    <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      func3_q       <= func3_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign ram_address    = ram_address_q;
  assign ram_data       = ram_data_q;
  assign ram_wren       = ram_wren_q;

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Load/store unit for `riscv_cpu`, downstream of its execute logic. It takes one memory request at a time from the core and drives the single-port, word-wide `ramm` RAM. That RAM has a synchronous read, one-cycle latency and no byte enables. The unit sign- or zero-extends load data, and performs SB/SH as a read-modify-write.

## Interface
- `ADDR_WIDTH`, 8: RAM word-address width. RAM depth is 2^ADDR_WIDTH words.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; a request is accepted on an edge where `req_valid & req_ready`.
- `req_store`  in  1  1 = store (SB/SH/SW), 0 = load.
- `req_func3`  in  3  RISC-V funct3 of the instruction.
- `req_addr`  in  32  byte address (rs1 + imm, computed by the core).
- `req_wdata`  in  32  store data (rs2).
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`: misaligned access or illegal funct3.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `ram_address`  out  ADDR_WIDTH  RAM word address, registered.
- `ram_data`  out  32  RAM write data, registered.
- `ram_wren`  out  1  RAM write enable, registered.
- `ram_q`  in  32  RAM read data, valid the cycle after the address is sampled.

## Operation
- Request fields are latched on acceptance. The core must hold `req_*` only until acceptance.
- Word address = `req_addr[ADDR_WIDTH+1:2]`. Upper bits are ignored, so addresses wrap modulo the RAM size.
- Byte lane = `req_addr[1:0]`, little-endian.
- Legal load funct3 values: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3 values: 000 SB, 001 SH, 010 SW.
- Anything else is illegal and gives an error response.
- Alignment rules:
  - Halfword requires `addr[0]=0`.
  - Word requires `addr[1:0]=00`.
  - Violations give an error response with no RAM access and `ram_wren` never asserted.
- Load extraction from `ram_q`:
  - LB/LBU select byte `[8*lane+7 : 8*lane]`.
  - LH/LHU select `[16*addr[1]+15 : 16*addr[1]]`.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- SB/SH: read the word, then replace only the addressed byte or halfword with `req_wdata[7:0]` or `req_wdata[15:0]`, then write back. All other bytes are preserved bit-exactly.
- SW: direct write, no read.
- FSM states:
  - IDLE: `req_ready=1`. On accept: error → RESP; SW → WRITE; load, SB or SH → READ.
  - READ: `ram_address` driven, `ram_wren=0`; → WAIT.
  - WAIT: `ram_q` valid. Load: register the extended data, → RESP. SB/SH: register the merged word into `ram_data`, set `ram_wren`, → WRITE.
  - WRITE: `ram_wren=1`; the RAM writes at the end of this cycle; → RESP.
  - RESP: `resp_valid=1` for exactly one cycle; → IDLE.
- `req_ready` is 1 only in IDLE. `req_valid` asserted in any other state is ignored and not queued.
- `ram_wren` is 1 only in WRITE.

## Timing
- Cycle 0 is the cycle the request is accepted; `resp_valid` rises in the cycle given below.
- Latency:
  - Error: cycle 1.
  - SW: cycle 2.
  - Load: cycle 3.
  - SB/SH: cycle 4.
- `req_ready` returns high the cycle after RESP.
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `ram_address=0`, `ram_data=0`, `ram_wren=0`.
- Reset asserted mid-operation:
  - All registers clear immediately and asynchronously, and no response is issued.
  - If reset is asserted before the WRITE-cycle edge, the RAM word is left unmodified.
  - If reset is asserted during WRITE, the write outcome is undefined; the bench must not check it.
- `resp_rdata` and `resp_err` hold their values until the next RESP; they are only meaningful while `resp_valid=1`.

## Test plan
- Preload word 5 = 0x80FF7F01.
  - LB at byte addr 0x17 → rdata 0xFFFFFF80.
  - LBU at 0x17 → 0x00000080.
  - LH at 0x16 → 0xFFFF80FF.
  - LHU at 0x14 → 0x00007F01.
  - LW at 0x14 → 0x80FF7F01.
  - Each with `resp_valid` in cycle 3.
- Preload word 2 = 0x11223344.
  - SB addr 0x09 data 0xAAAAAAAA → word 2 = 0x1122AA44, `resp_valid` in cycle 4.
  - SH addr 0x0A data 0x0000BEEF → word 2 = 0xBEEFAA44.
- SW addr 0x0C data 0xDEADBEEF: `ram_wren` high in cycle 1 only, `resp_valid` in cycle 2. A following LW at 0x0C returns 0xDEADBEEF.
- Error cases, each giving `resp_err=1` in cycle 1 with `ram_wren` never asserted and memory unchanged:
  - LW at 0x02.
  - SH at 0x03.
  - Load funct3 011.
  - Store funct3 100.
- With `ADDR_WIDTH=8`, LW at 0x00000404 returns the contents of word 1 (address wraps).
- Back-to-back: hold `req_valid` high with two loads. The second is accepted only once `req_ready` returns high, the cycle after the first `resp_valid`.
- Reset pulse during the WAIT state of an SB → target word unchanged, `resp_valid` never asserted, `req_ready=1` immediately.
